// File: rtl/rv32_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_sched_pkg
// Description : Shared types and constants for the rv32 hart scheduler and
//               its round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_sched_pkg;

  // Per-hart run state, typed view.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    TRAP = 2'd3
  } rv_hart_state_t;

  // Encodings used by the per-hart state registers. These are kept as plain
  // 2-bit constants so legacy blocks that carry state as logic [1:0] can share them.
  localparam logic [1:0] c_st_idle = IDLE;
  localparam logic [1:0] c_st_run  = RUN;
  localparam logic [1:0] c_st_wait = WAIT;
  localparam logic [1:0] c_st_trap = TRAP;

  // Widest hart id the scheduler supports (32 harts).
  localparam int c_max_harts = 32;
  localparam int c_max_hid_w = $clog2(c_max_harts);
  typedef logic [c_max_hid_w-1:0] rv_hart_id_t;

endpackage
`default_nettype wire

// File: rtl/rv32_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32_rr_arbiter
// Description : Combinational round-robin pick. Scans last_grant+1,
//               last_grant+2, ... (modulo NUM_REQ) and returns the first
//               asserted request. NUM_REQ must be a power of two so the id
//               arithmetic wraps naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_rr_arbiter #(
  parameter  int NUM_REQ = 8,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] w_idx;

  // First request after the previous winner; offset NUM_REQ wraps onto last_grant itself.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = last_grant + ID_W'(k);
      if (!grant_valid && req[w_idx]) begin
        grant_valid = 1'b1;
        grant_id    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv32_hart_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rv32_hart_scheduler
// Description : Barrel-style hart scheduler in front of fetch. Keeps run
//               state and PC per hart and issues one (hart, PC) per accepted
//               cycle, round-robin over RUN harts, through a single-register
//               issue slot. Retire feedback returns a hart to RUN or parks
//               it in TRAP.
//               Optional build macro RV32_SCHED_PERF_EN adds the
//               perf_issue_cnt / perf_idle_cnt counters.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_hart_scheduler
  import rv32_sched_pkg::*;
#(
  parameter  int NUM_HARTS = 8,
  parameter  int PC_W      = 32,
  localparam int HID_W     = $clog2(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_HARTS-1:0] hart_start,
  input  logic [PC_W-1:0]      hart_start_pc,
  input  logic [NUM_HARTS-1:0] trap_clear,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [HID_W-1:0]     issue_hart_id,
  output logic [PC_W-1:0]      issue_pc,
  input  logic                 retire_valid,
  input  logic [HID_W-1:0]     retire_hart_id,
  input  logic [PC_W-1:0]      retire_next_pc,
  input  logic                 retire_trap,
`ifdef RV32_SCHED_PERF_EN
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_idle_cnt,
`endif
  output logic [NUM_HARTS-1:0] hart_running,
  output logic [NUM_HARTS-1:0] hart_trapped
);

  logic                 r_issue_valid;
  logic [HID_W-1:0]     r_issue_hart_id;
  logic [PC_W-1:0]      r_issue_pc;
  logic [HID_W-1:0]     r_last_grant;

  logic [NUM_HARTS-1:0] w_run_req;
  logic [PC_W-1:0]      w_pc_arr [NUM_HARTS];
  logic                 w_grant_valid;
  logic [HID_W-1:0]     w_grant_id;
  logic                 w_slot_load;

  // The slot refills when it is empty or its current content is being taken.
  assign w_slot_load = !r_issue_valid || issue_ready;

  rv32_rr_arbiter #(
    .NUM_REQ (NUM_HARTS)
  ) u_arb (
    .req         (w_run_req),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  // Issue slot: loads the arbiter winner, or empties when no hart is in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_valid   <= 1'b0;
      r_issue_hart_id <= '0;
      r_issue_pc      <= '0;
      r_last_grant    <= HID_W'(NUM_HARTS - 1);
    end else if (w_slot_load) begin
      r_issue_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_issue_hart_id <= w_grant_id;
        r_issue_pc      <= w_pc_arr[w_grant_id];
        r_last_grant    <= w_grant_id;
      end
    end
  end

  assign issue_valid   = r_issue_valid;
  assign issue_hart_id = r_issue_hart_id;
  assign issue_pc      = r_issue_pc;

  for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            w_granted;
    logic            w_retire_hit;

    // A RUN hart leaves candidacy the same edge it enters the slot, so it
    // cannot be issued twice before its retire comes back.
    assign w_granted    = w_slot_load && w_grant_valid && (w_grant_id == HID_W'(gi));
    assign w_retire_hit = retire_valid && (retire_hart_id == HID_W'(gi));

    // Per-hart run state; events not matching the current state are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= c_st_idle;
        r_pc    <= '0;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (hart_start[gi]) begin
              r_state <= c_st_run;
              r_pc    <= hart_start_pc;
            end
          end
          c_st_run: begin
            if (w_granted) begin
              r_state <= c_st_wait;
            end
          end
          c_st_wait: begin
            if (w_retire_hit) begin
              if (retire_trap) begin
                r_state <= c_st_trap;       // PC kept: it is the faulting PC
              end else begin
                r_state <= c_st_run;
                r_pc    <= retire_next_pc;
              end
            end
          end
          default: begin
            // TRAP: a start in the same cycle as the clear is ignored.
            if (trap_clear[gi]) begin
              r_state <= c_st_idle;
            end
          end
        endcase
      end
    end

    assign w_run_req[gi]    = (r_state == c_st_run);
    assign w_pc_arr[gi]     = r_pc;
    assign hart_running[gi] = (r_state == c_st_run) || (r_state == c_st_wait);
    assign hart_trapped[gi] = (r_state == c_st_trap);
  end

`ifdef RV32_SCHED_PERF_EN
  logic [31:0] r_perf_issue_cnt;
  logic [31:0] r_perf_idle_cnt;

  // Free-running, wrapping counts of accepted issues and empty-slot cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_issue_cnt <= '0;
      r_perf_idle_cnt  <= '0;
    end else begin
      if (r_issue_valid && issue_ready) begin
        r_perf_issue_cnt <= r_perf_issue_cnt + 32'd1;
      end
      if (!r_issue_valid) begin
        r_perf_idle_cnt <= r_perf_idle_cnt + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = r_perf_issue_cnt;
  assign perf_idle_cnt  = r_perf_idle_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32_hart_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rv32_hart_scheduler
// Description : Scoreboard bench for rv32_hart_scheduler. A behavioural
//               model predicts each slot load and pushes it to a queue; a
//               monitor pops on every handshake. Directed scenarios plus a
//               randomized phase. Honours RV32_SCHED_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_hart_scheduler;

  localparam int N  = 8;
  localparam int PW = 32;
  localparam int HW = 3;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_WAIT = 2;
  localparam int S_TRAP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  hart_start;
  logic [PW-1:0] hart_start_pc;
  logic [N-1:0]  trap_clear;
  logic          issue_valid;
  logic          issue_ready;
  logic [HW-1:0] issue_hart_id;
  logic [PW-1:0] issue_pc;
  logic          retire_valid;
  logic [HW-1:0] retire_hart_id;
  logic [PW-1:0] retire_next_pc;
  logic          retire_trap;
  logic [N-1:0]  hart_running;
  logic [N-1:0]  hart_trapped;
`ifdef RV32_SCHED_PERF_EN
  logic [31:0]   perf_issue_cnt;
  logic [31:0]   perf_idle_cnt;
`endif

  always #5 clk = ~clk;

  rv32_hart_scheduler #(
    .NUM_HARTS (N),
    .PC_W      (PW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hart_start     (hart_start),
    .hart_start_pc  (hart_start_pc),
    .trap_clear     (trap_clear),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_hart_id  (issue_hart_id),
    .issue_pc       (issue_pc),
    .retire_valid   (retire_valid),
    .retire_hart_id (retire_hart_id),
    .retire_next_pc (retire_next_pc),
    .retire_trap    (retire_trap),
`ifdef RV32_SCHED_PERF_EN
    .perf_issue_cnt (perf_issue_cnt),
    .perf_idle_cnt  (perf_idle_cnt),
`endif
    .hart_running   (hart_running),
    .hart_trapped   (hart_trapped)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            id;
    logic [PW-1:0] pc;
  } slot_t;

  int            m_st  [N];
  int            m_pre [N];
  logic [PW-1:0] m_pc  [N];
  bit            m_valid;
  int            m_last;
  int            m_pick;
  logic [31:0]   m_issue_cnt;
  logic [31:0]   m_idle_cnt;
  slot_t         exp_q[$];

  int            log_id[$];
  logic [PW-1:0] log_pc[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_st[i] = S_IDLE;
        m_pc[i] = '0;
      end
      m_valid     = 1'b0;
      m_last      = N - 1;
      m_issue_cnt = '0;
      m_idle_cnt  = '0;
      exp_q.delete();
    end else begin
      m_pre = m_st;
      if (m_valid && issue_ready) m_issue_cnt = m_issue_cnt + 1;
      if (!m_valid) m_idle_cnt = m_idle_cnt + 1;
      if (!m_valid || issue_ready) begin
        m_pick = -1;
        for (int k = 1; k <= N; k++) begin
          if (m_pick < 0 && m_pre[(m_last + k) % N] == S_RUN) m_pick = (m_last + k) % N;
        end
        if (m_pick >= 0) begin
          m_valid = 1'b1;
          m_last  = m_pick;
          exp_q.push_back('{m_pick, m_pc[m_pick]});
          m_st[m_pick] = S_WAIT;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (m_pre[i] == S_IDLE && hart_start[i]) begin
          m_st[i] = S_RUN;
          m_pc[i] = hart_start_pc;
        end else if (m_pre[i] == S_WAIT && retire_valid && int'(retire_hart_id) == i) begin
          if (retire_trap) m_st[i] = S_TRAP;
          else begin
            m_st[i] = S_RUN;
            m_pc[i] = retire_next_pc;
          end
        end else if (m_pre[i] == S_TRAP && trap_clear[i]) begin
          m_st[i] = S_IDLE;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [N-1:0] mon_run, mon_trap;
  slot_t        mon_head;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        mon_run[i]  = (m_st[i] == S_RUN) || (m_st[i] == S_WAIT);
        mon_trap[i] = (m_st[i] == S_TRAP);
      end
      chk("issue_valid", 64'(issue_valid), 64'(m_valid));
      chk("hart_running", 64'(hart_running), 64'(mon_run));
      chk("hart_trapped", 64'(hart_trapped), 64'(mon_trap));
`ifdef RV32_SCHED_PERF_EN
      chk("perf_issue_cnt", 64'(perf_issue_cnt), 64'(m_issue_cnt));
      chk("perf_idle_cnt", 64'(perf_idle_cnt), 64'(m_idle_cnt));
`endif
      if (issue_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("slot_unexpected", 64'(issue_valid), 64'd0);
        end else begin
          mon_head = exp_q[0];
          chk("slot_hart_id", 64'(issue_hart_id), 64'(mon_head.id));
          chk("slot_pc", 64'(issue_pc), 64'(mon_head.pc));
          if (issue_ready) begin
            void'(exp_q.pop_front());
            log_id.push_back(int'(issue_hart_id));
            log_pc.push_back(issue_pc);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    hart_start     = '0;
    hart_start_pc  = '0;
    trap_clear     = '0;
    retire_valid   = 1'b0;
    retire_hart_id = '0;
    retire_next_pc = '0;
    retire_trap    = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    log_id.delete();
    log_pc.delete();
  endtask

  task automatic retire(input int id, input logic [PW-1:0] npc, input logic trap);
    retire_valid   = 1'b1;
    retire_hart_id = HW'(id);
    retire_next_pc = npc;
    retire_trap    = trap;
    tick(1);
    idle_inputs();
  endtask

  task automatic start(input logic [N-1:0] mask, input logic [PW-1:0] pc);
    hart_start    = mask;
    hart_start_pc = pc;
    tick(1);
    idle_inputs();
  endtask

  task automatic check_scenario1(input string tag);
    chk({tag, "_count"}, 64'(log_id.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_id.size()) begin
        chk($sformatf("%s_id%0d", tag, i), 64'(log_id[i]), 64'(i));
        chk($sformatf("%s_pc%0d", tag, i), 64'(log_pc[i]), 64'h100);
      end
    end
    chk({tag, "_drained"}, 64'(issue_valid), 64'd0);
  endtask

  int           wq[$];
  int           rid;

  initial begin
    idle_inputs();
    issue_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_issue_hart_id", 64'(issue_hart_id), 64'd0);
    chk("rst_issue_pc", 64'(issue_pc), 64'd0);
    chk("rst_hart_running", 64'(hart_running), 64'd0);
    chk("rst_hart_trapped", 64'(hart_trapped), 64'd0);
    rst_n = 1'b1;
    tick(1);

    // 1: reset ordering
    clear_log();
    issue_ready = 1'b1;
    start(8'h0F, 32'h100);
    tick(7);
    check_scenario1("s1");

    // 2: retire and reissue
    clear_log();
    retire(2, 32'h104, 1'b0);
    tick(4);
    chk("s2_count", 64'(log_id.size()), 64'd1);
    if (log_id.size() > 0) begin
      chk("s2_id", 64'(log_id[0]), 64'd2);
      chk("s2_pc", 64'(log_pc[0]), 64'h104);
    end

    // 3: backpressure with hart 1 held in the slot
    clear_log();
    issue_ready = 1'b0;
    retire(1, 32'h108, 1'b0);
    retire(0, 32'h10C, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("s3_valid", 64'(issue_valid), 64'd1);
      chk("s3_id", 64'(issue_hart_id), 64'd1);
      chk("s3_pc", 64'(issue_pc), 64'h108);
      chk("s3_h0_running", 64'(hart_running[0]), 64'd1);
      tick(1);
    end
    issue_ready = 1'b1;
    tick(4);
    chk("s3_count", 64'(log_id.size()), 64'd2);
    if (log_id.size() > 1) begin
      chk("s3_first", 64'(log_id[0]), 64'd1);
      chk("s3_second", 64'(log_id[1]), 64'd0);
      chk("s3_second_pc", 64'(log_pc[1]), 64'h10C);
    end

    // 4: trap path
    clear_log();
    retire(3, 32'hDEAD_0000, 1'b1);
    tick(1);
    chk("s4_trapped", 64'(hart_trapped[3]), 64'd1);
    chk("s4_not_running", 64'(hart_running[3]), 64'd0);
    tick(5);
    chk("s4_no_issue", 64'(log_id.size()), 64'd0);
    trap_clear = 8'h08;
    tick(1);
    idle_inputs();
    chk("s4_cleared", 64'(hart_trapped[3]), 64'd0);
    chk("s4_idle", 64'(hart_running[3]), 64'd0);
    start(8'h08, 32'h200);
    tick(4);
    chk("s4_restart_count", 64'(log_id.size()), 64'd1);
    if (log_id.size() > 0) begin
      chk("s4_restart_id", 64'(log_id[0]), 64'd3);
      chk("s4_restart_pc", 64'(log_pc[0]), 64'h200);
    end

    // 5: simultaneous clear+start on TRAP hart, spurious retire
    start(8'h20, 32'h300);
    tick(4);
    retire(5, 32'h0, 1'b1);
    chk("s5_trapped", 64'(hart_trapped[5]), 64'd1);
    hart_start    = 8'h20;
    hart_start_pc = 32'h400;
    trap_clear    = 8'h20;
    tick(1);
    idle_inputs();
    chk("s5_not_running", 64'(hart_running[5]), 64'd0);
    chk("s5_not_trapped", 64'(hart_trapped[5]), 64'd0);
    tick(3);
    chk("s5_still_idle", 64'(hart_running[5]), 64'd0);
    clear_log();
    retire(6, 32'h500, 1'b0);
    tick(3);
    chk("s5_spurious_retire", 64'(hart_running[6]), 64'd0);
    chk("s5_spurious_no_issue", 64'(log_id.size()), 64'd0);

    // 6: asynchronous reset with the slot full
    issue_ready = 1'b0;
    start(8'hFF, 32'h600);
    tick(2);
    chk("s6_slot_full", 64'(issue_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_valid_dropped", 64'(issue_valid), 64'd0);
    chk("s6_hart_id", 64'(issue_hart_id), 64'd0);
    chk("s6_pc", 64'(issue_pc), 64'd0);
    chk("s6_running", 64'(hart_running), 64'd0);
    chk("s6_trapped", 64'(hart_trapped), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1);
    clear_log();
    issue_ready = 1'b1;
    start(8'h0F, 32'h100);
    tick(7);
    check_scenario1("s6_rerun");
`ifdef RV32_SCHED_PERF_EN
    chk("s6_perf_issue", 64'(perf_issue_cnt), 64'd4);
`endif

    // randomized phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_inputs();
      issue_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        hart_start    = N'($urandom);
        hart_start_pc = $urandom & 32'hFFFF_FFFC;
      end
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == S_TRAP && $urandom_range(0, 3) == 0) trap_clear[i] = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) trap_clear = trap_clear | N'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i < N; i++) if (m_st[i] == S_WAIT) wq.push_back(i);
        if (wq.size() > 0 && $urandom_range(0, 4) != 0) rid = wq[$urandom_range(0, wq.size() - 1)];
        else rid = $urandom_range(0, N - 1);
        retire_valid   = 1'b1;
        retire_hart_id = HW'(rid);
        retire_next_pc = $urandom & 32'hFFFF_FFFC;
        retire_trap    = ($urandom_range(0, 7) == 0);
      end
      tick(1);
    end
    idle_inputs();
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
